stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Registered 1-to-NUM_OUT demultiplexer for a valid/ready stream.
- Each accepted word is steered by in_sel into a small per-output FIFO.
- Each output drains independently under its own ready.
- Used to fan a single producer (e.g. a datapath result bus) out to several consumers. This is the complement of the combinational mux primitives.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_OUT, 2, number of output channels (>= 2; need not be a power of two).
- DEPTH, 2, entries per output FIFO (>= 1).
- SEL_W, $clog2(NUM_OUT), derived localparam: select width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination index for in_data.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the word addressed by in_sel.
- out_data  out  NUM_OUT*WIDTH  packed; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  channel k head entry valid.
- out_ready  in  NUM_OUT  consumer k takes head entry.
- err_sel  out  1  one-cycle pulse: a word with out-of-range in_sel was dropped.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port name reset.
- On reset assertion, immediately:
  - every FIFO is emptied (count=0, pointers=0);
  - out_valid=0, err_sel=0, out_data=0.
- Reset mid-operation discards all buffered words. Nothing is replayed after release.
- Per-channel FIFO k: circular buffer of DEPTH entries with rd_ptr, wr_ptr and count in 0..DEPTH. Pointers wrap from DEPTH-1 to 0.
- out_valid[k] = (count_k != 0). out_data slice k = entry[rd_ptr_k], registered storage only.
- in_ready:
  - = (in_sel >= NUM_OUT) ? 1 : (count[in_sel] != DEPTH).
  - Combinational on in_sel and state only. Never depends on out_ready or in_valid.
- Accept: in_valid & in_ready at the edge.
  - In-range sel: write entry[wr_ptr], increment wr_ptr and count.
  - Out-of-range sel: word discarded, err_sel=1 for the next cycle only. Only possible when NUM_OUT is not a power of two.
- Pop: out_valid[k] & out_ready[k] at the edge: increment rd_ptr_k, decrement count_k.
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel after edge N (one cycle). No combinational input-to-output path.
- Simultaneous push and pop on the same channel:
  - count unchanged, both pointers advance.
  - When full, the push is still refused (in_ready=0 that cycle); there is no pass-through.
- Pops on different channels are fully independent. Any subset of channels may pop in one cycle.
- Ordering: words to the same channel leave in acceptance order. There is no ordering guarantee across channels.
- A full channel never blocks words addressed to other channels (in_ready is per-sel).
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro STREAM_DEMUX_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored and in_ready = all NUM_OUT FIFOs not full.
  - On accept, the word is written into every FIFO in the same edge.
  - err_sel never fires for broadcast words.
- Undefined: port in_bcast absent; only unicast behaviour as above.

Test Plan:
- Reset/idle: assert reset mid-cycle with no clk edge -> out_valid=0, err_sel=0 immediately. After release with in_valid=0 for 5 cycles -> out_valid stays 0.
- Basic steer (NUM_OUT=2, DEPTH=2): send 0xA1 sel=0, then 0xB2 sel=1, out_ready=2'b11 -> ch0 shows 0xA1 and ch1 shows 0xB2, each one cycle after its accept, valid for exactly one cycle.
- Full/backpressure:
  - out_ready=0; send 0x01, 0x02, 0x03 to sel=0 -> first two accepted; in_ready=0 on the third while sel=0.
  - Switching to sel=1 with 0x04 -> in_ready=1, accepted.
  - Release out_ready[0] -> ch0 delivers 0x01 then 0x02 in order.
- Simultaneous push/pop at full:
  - ch0 holds 0x10, 0x11; out_ready[0]=1 and push 0x12 same cycle -> push refused, 0x10 popped.
  - Next cycle 0x12 accepted; drain order is 0x11, 0x12.
- Out-of-range select (NUM_OUT=3): send 0x55 with sel=3 -> in_ready=1, no out_valid change, err_sel=1 for exactly one cycle.
- Reset mid-operation: fill ch0 with 2 words, pulse reset for 1 cycle -> out_valid=0 at once; after release, a new word 0x77 to sel=0 is the first delivered.
- Broadcast (macro defined): in_bcast=1, data 0xC3 -> every out_valid bit set next cycle with 0xC3. If any channel is full -> in_ready=0 and no channel is written.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_OUT demultiplexer for a valid/ready
// stream. Each accepted word is steered by in_sel into a small per-output
// circular FIFO; every output drains independently under its own ready.
//
// Optional feature: define STREAM_DEMUX_BCAST_EN to add the in_bcast port.
// A broadcast word ignores in_sel, needs room in every FIFO and is written
// into all of them on the same edge.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-high reset, empties every FIFO
//   in_data    input word
//   in_sel     destination channel index for in_data
//   in_valid   input word present
//   in_bcast   (STREAM_DEMUX_BCAST_EN only) write the word to all channels
//   in_ready   the word addressed by in_sel can be taken this cycle
//   out_data   packed channel heads, channel k at [k*WIDTH +: WIDTH]
//   out_valid  channel k head entry valid
//   out_ready  consumer k takes its head entry
//   err_sel    one-cycle pulse: a word with out-of-range in_sel was dropped
module stream_demux #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned SEL_W  = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     err_sel
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem    [NUM_OUT][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_OUT];
  logic [PTR_W-1:0] wr_ptr [NUM_OUT];
  logic [CNT_W-1:0] count  [NUM_OUT];

  logic [NUM_OUT-1:0] hit;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic               in_range;
  logic               bcast;
  logic               accept;
  logic               drop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Select decode and per-channel status. in_ready only looks at in_sel
  // (or in_bcast) and registered state, never at in_valid or out_ready,
  // so a full channel refuses a push even while it is being popped.
  always_comb begin
    hit  = '0;
    full = '0;
    pop  = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      hit[k]  = (in_sel == SEL_W'(k));
      full[k] = (count[k] == CNT_W'(DEPTH));
      pop[k]  = (count[k] != '0) && out_ready[k];
    end
    in_range = |hit;
    if (bcast) begin
      in_ready = ~|full;
    end else if (in_range) begin
      in_ready = |(hit & ~full);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid && in_ready;
    drop   = accept && !bcast && !in_range;
    push   = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      push[k] = accept && (bcast || hit[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
          mem[k][e] <= '0;
        end
      end
      err_sel <= 1'b0;
    end else begin
      err_sel <= drop;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_data;
          wr_ptr[k]         <= ptr_next(wr_ptr[k]);
        end
        if (pop[k]) begin
          rd_ptr[k] <= ptr_next(rd_ptr[k]);
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // Heads are read straight out of the storage registers.
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_data[k*WIDTH +: WIDTH] = mem[k][rd_ptr[k]];
      out_valid[k]               = (count[k] != '0);
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  localparam int NOUT = 3;
  localparam int DEP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        bcast = 1'b0;
  logic        in_ready;
  logic [23:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = '0;
  logic        err_sel;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] q [NOUT][$];

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .NUM_OUT(NOUT), .DEPTH(DEP)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bcast),
`endif
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sel(err_sel)
  );

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [2:0] ordy;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_rdy();
    if (bcast) begin
      for (int k = 0; k < NOUT; k++) if (q[k].size() >= DEP) return 1'b0;
      return 1'b1;
    end
    if (int'(in_sel) >= NOUT) return 1'b1;
    return q[in_sel].size() < DEP;
  endfunction

  // One clock: check combinational/registered outputs against the model,
  // take the edge, update the scoreboard, then check err_sel.
  task automatic cycle();
    logic exp_rdy;
    logic acc;
    logic exp_err;
    logic [2:0] popv;
    #1;
    exp_rdy = model_rdy();
    chk("in_ready", in_ready, exp_rdy);
    popv = '0;
    for (int k = 0; k < NOUT; k++) begin
      chk($sformatf("out_valid[%0d]", k), out_valid[k], q[k].size() != 0);
      if (q[k].size() != 0) begin
        chk($sformatf("out_data[%0d]", k), out_data[k*8 +: 8], q[k][0]);
        popv[k] = out_ready[k];
      end
    end
    acc = in_valid && exp_rdy;
    exp_err = acc && !bcast && (int'(in_sel) >= NOUT);
    @(posedge clk);
    for (int k = 0; k < NOUT; k++) begin
      if (popv[k]) void'(q[k].pop_front());
      if (acc && (bcast || int'(in_sel) == k)) q[k].push_back(in_data);
    end
    #1;
    chk("err_sel", err_sel, exp_err);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NOUT; k++) q[k].delete();
  endtask

  initial begin
    // v, sel, data, out_ready, expected in_ready, expected err_sel next
    tbl[0]  = '{1'b1, 2'd0, 8'hA1, 3'b011, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 8'hB2, 3'b011, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 3'b011, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 3'b000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 8'h01, 3'b000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 8'h02, 3'b000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 8'h03, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 8'h04, 3'b000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 3'b001, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 3'b001, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 3'b010, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 8'h55, 3'b000, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 3'b000, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 8'h66, 3'b000, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 3'b100, 1'b1, 1'b0};

    // Reset held from time zero, checked before any clock edge.
    #3;
    chk("rst_out_valid", out_valid, 3'b000);
    chk("rst_err_sel", err_sel, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    @(negedge clk);
    reset = 1'b0;

    drive(1'b0, 2'd0, 8'h00, 3'b000);
    for (int i = 0; i < 5; i++) cycle();

    // Table-driven steer, backpressure and out-of-range select.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_err_sel", i), err_sel, tbl[i].err);
    end

    // Simultaneous push/pop on a full channel: push refused, pop proceeds.
    drive(1'b1, 2'd0, 8'h10, 3'b000); cycle();
    drive(1'b1, 2'd0, 8'h11, 3'b000); cycle();
    drive(1'b1, 2'd0, 8'h12, 3'b001);
    #1;
    chk("pp_push_refused", in_ready, 1'b0);
    cycle();
    drive(1'b1, 2'd0, 8'h12, 3'b000);
    #1;
    chk("pp_push_next", in_ready, 1'b1);
    cycle();
    drive(1'b0, 2'd0, 8'h00, 3'b001);
    cycle();
    cycle();
    chk("pp_drained", out_valid, 3'b000);

    // Reset mid-operation, asserted and released between clock edges.
    drive(1'b1, 2'd0, 8'h20, 3'b000); cycle();
    drive(1'b1, 2'd0, 8'h21, 3'b000); cycle();
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("pre_rst_valid", out_valid, 3'b001);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 3'b000);
    chk("mid_rst_out_data", out_data, 24'h0);
    chk("mid_rst_err_sel", err_sel, 1'b0);
    clear_model();
    #2;
    reset = 1'b0;
    drive(1'b1, 2'd0, 8'h77, 3'b000); cycle();
    drive(1'b0, 2'd0, 8'h00, 3'b001);
    cycle();
    cycle();

`ifdef STREAM_DEMUX_BCAST_EN
    // Broadcast to every channel, then a refused broadcast while ch0 is full.
    bcast = 1'b1;
    drive(1'b1, 2'd1, 8'hC3, 3'b000);
    cycle();
    chk("bc_all_valid", out_valid, 3'b111);
    bcast = 1'b0;
    drive(1'b1, 2'd0, 8'h5A, 3'b000); cycle();
    bcast = 1'b1;
    drive(1'b1, 2'd1, 8'hD4, 3'b000);
    #1;
    chk("bc_full_refused", in_ready, 1'b0);
    cycle();
    bcast = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    for (int i = 0; i < 3; i++) cycle();
    chk("bc_drained", out_valid, 3'b000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
